// File: rtl/lms_ctr_dpram_avmm_if.sv
// Avalon-MM pipelined slave bundle for one port of the lms_ctr dual-port RAM.
// Fields: address/chipselect/read/write/byteenable/writedata from master; readdata/readdatavalid/waitrequest to master.
interface lms_ctr_dpram_avmm_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0]   address;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/lms_ctr_dpram_avmm.sv
// True-dual-port RAM with two Avalon-MM pipelined slaves, optional clear after reset.
// Ports: clk, reset_n, clken, reset_req, s1 (port A), s2 (port B), init_done, collision.
module lms_ctr_dpram_avmm #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 1024,
   parameter bit OUT_REG        = 1'b0,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clken,
   input  logic reset_req,
   lms_ctr_dpram_avmm_if.slave s1,
   lms_ctr_dpram_avmm_if.slave s2,
   output logic init_done,
   output logic collision
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int NB     = DATA_W / 8;
   localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W:0]   clr_addr;
   logic [ADDR_W:0]   clr_addr_nxt;

   logic              en;
   logic              busy;
   logic              a_acc, a_wr, a_rd;
   logic              b_acc, b_wr, b_rd;
   logic              coll;
   logic              b_wr_ok;
   logic              clearing;

   logic              wa_en;
   logic [ADDR_W-1:0] wa_addr;
   logic [NB-1:0]     wa_be;
   logic [DATA_W-1:0] wa_data;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] a_q, a_d2;
   logic [DATA_W-1:0] b_q, b_d2;
   logic              a_v1, a_v2;
   logic              b_v1, b_v2;

   assign en   = clken & ~reset_req;
   assign busy = ~en | ~init_done;

   // a simultaneous read+write is taken as a write only
   assign a_acc = s1.chipselect & (s1.read | s1.write) & ~busy;
   assign a_wr  = a_acc & s1.write;
   assign a_rd  = a_acc & s1.read & ~s1.write;
   assign b_acc = s2.chipselect & (s2.read | s2.write) & ~busy;
   assign b_wr  = b_acc & s2.write;
   assign b_rd  = b_acc & s2.read & ~s2.write;

   // same-address double write: A wins, B is dropped in full
   assign coll    = a_wr & b_wr & (s1.address == s2.address);
   assign b_wr_ok = b_wr & ~coll;

   // the clear borrows write port A; hosts are stalled meanwhile
   assign clearing = en & (state == CLEAR);
   assign wa_en    = clearing | a_wr;
   assign wa_addr  = clearing ? clr_addr[ADDR_W-1:0] : s1.address;
   assign wa_be    = clearing ? '1 : s1.byteenable;
   assign wa_data  = clearing ? '0 : s1.writedata;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wa_en && wa_be[i])
            mem[wa_addr][8*i +: 8] <= wa_data[8*i +: 8];
         if (b_wr_ok && s2.byteenable[i])
            mem[s2.address][8*i +: 8] <= s2.writedata[8*i +: 8];
      end
   end

   // read registers load only on an accepted read so data holds otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q  <= '0;
         b_q  <= '0;
         a_d2 <= '0;
         b_d2 <= '0;
         a_v1 <= 1'b0;
         a_v2 <= 1'b0;
         b_v1 <= 1'b0;
         b_v2 <= 1'b0;
      end else if (en) begin
         if (a_rd) a_q <= mem[s1.address];
         if (b_rd) b_q <= mem[s2.address];
         if (a_v1) a_d2 <= a_q;
         if (b_v1) b_d2 <= b_q;
         a_v1 <= a_rd;
         a_v2 <= a_v1;
         b_v1 <= b_rd;
         b_v2 <= b_v1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         collision <= 1'b0;
      else if (en && coll)
         collision <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= CLEAR_ON_RESET ? CLEAR : RUN;
         clr_addr <= '0;
      end else if (en) begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      unique case (state)
         CLEAR: begin
            clr_addr_nxt = clr_addr + 1'b1;
            if (clr_addr == LAST)
               state_nxt = RUN;
         end
         RUN: ;
      endcase
   end

   assign init_done = (state == RUN);

   // valid is masked while stalled so a held pulse is seen exactly once
   assign s1.readdata      = OUT_REG ? a_d2 : a_q;
   assign s2.readdata      = OUT_REG ? b_d2 : b_q;
   assign s1.readdatavalid = en & (OUT_REG ? a_v2 : a_v1);
   assign s2.readdatavalid = en & (OUT_REG ? b_v2 : b_v1);
   assign s1.waitrequest   = busy;
   assign s2.waitrequest   = busy;
endmodule

// File: tb/tb_lms_ctr_dpram_avmm.sv
// Scoreboard bench: two DUTs (OUT_REG=0 and 1, DEPTH=16) driven in lockstep.
// Reads push expected data and due cycle; a negedge monitor pops and compares.
module tb_lms_ctr_dpram_avmm;
   logic clk = 1'b0;
   logic reset_n, clken, reset_req;
   logic done0, done1, coll0, coll1;

   logic       a_cs, a_rd, a_wr, b_cs, b_rd, b_wr;
   logic [3:0] a_ad, a_be, b_ad, b_be;
   logic [31:0] a_wd, b_wd;

   int checks = 0;
   int errors = 0;
   int negcnt = 0;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t sb [4][$];

   always #5 clk = ~clk;

   lms_ctr_dpram_avmm_if #(.DATA_W(32), .ADDR_W(4)) ia0 ();
   lms_ctr_dpram_avmm_if #(.DATA_W(32), .ADDR_W(4)) ib0 ();
   lms_ctr_dpram_avmm_if #(.DATA_W(32), .ADDR_W(4)) ia1 ();
   lms_ctr_dpram_avmm_if #(.DATA_W(32), .ADDR_W(4)) ib1 ();

   assign ia0.address = a_ad;  assign ia1.address = a_ad;
   assign ia0.chipselect = a_cs; assign ia1.chipselect = a_cs;
   assign ia0.read = a_rd;     assign ia1.read = a_rd;
   assign ia0.write = a_wr;    assign ia1.write = a_wr;
   assign ia0.byteenable = a_be; assign ia1.byteenable = a_be;
   assign ia0.writedata = a_wd; assign ia1.writedata = a_wd;
   assign ib0.address = b_ad;  assign ib1.address = b_ad;
   assign ib0.chipselect = b_cs; assign ib1.chipselect = b_cs;
   assign ib0.read = b_rd;     assign ib1.read = b_rd;
   assign ib0.write = b_wr;    assign ib1.write = b_wr;
   assign ib0.byteenable = b_be; assign ib1.byteenable = b_be;
   assign ib0.writedata = b_wd; assign ib1.writedata = b_wd;

   lms_ctr_dpram_avmm #(
      .DATA_W(32), .DEPTH(16), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1(ia0), .s2(ib0), .init_done(done0), .collision(coll0)
   );

   lms_ctr_dpram_avmm #(
      .DATA_W(32), .DEPTH(16), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1(ia1), .s2(ib1), .init_done(done1), .collision(coll1)
   );

   logic [3:0]  rv;
   logic [31:0] rdat [4];

   assign rv = {ib1.readdatavalid, ia1.readdatavalid,
                ib0.readdatavalid, ia0.readdatavalid};
   assign rdat[0] = ia0.readdata;
   assign rdat[1] = ib0.readdata;
   assign rdat[2] = ia1.readdata;
   assign rdat[3] = ib1.readdata;

   always @(negedge clk) begin
      exp_t e;
      negcnt++;
      for (int i = 0; i < 4; i++) begin
         if (rv[i] === 1'b1) begin
            checks++;
            if (sb[i].size() == 0) begin
               errors++;
               $display("FAIL rdv%0d unexpected: data=%h at %0d", i, rdat[i], negcnt);
            end else begin
               e = sb[i].pop_front();
               if (rdat[i] !== e.d || negcnt != e.due) begin
                  errors++;
                  $display("FAIL rd%0d: got %h at %0d, want %h at %0d",
                           i, rdat[i], negcnt, e.d, e.due);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_cs = 0; a_rd = 0; a_wr = 0; a_ad = 0; a_be = 0; a_wd = 0;
      b_cs = 0; b_rd = 0; b_wr = 0; b_ad = 0; b_be = 0; b_wd = 0;
   endtask

   // port 0 = A, 1 = B; dut0 latency 1, dut1 latency 2
   task automatic expect_rd(input int port, input logic [31:0] d, input int stall);
      exp_t e;
      e.d   = d;
      e.due = negcnt + 2 + stall;
      sb[port].push_back(e);
      e.due = negcnt + 3 + stall;
      sb[port + 2].push_back(e);
   endtask

   task automatic issue(
      input logic ar, input logic aw, input logic [3:0] aad,
      input logic [3:0] abe, input logic [31:0] awd,
      input logic br, input logic bw, input logic [3:0] bad,
      input logic [3:0] bbe, input logic [31:0] bwd
   );
      a_cs = ar | aw; a_rd = ar; a_wr = aw; a_ad = aad; a_be = abe; a_wd = awd;
      b_cs = br | bw; b_rd = br; b_wr = bw; b_ad = bad; b_be = bbe; b_wd = bwd;
      cyc();
   endtask

   task automatic count_wait(output int n);
      n = 0;
      @(negedge clk);
      while (ia0.waitrequest && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim did not finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      idle();
      reset_n = 0; clken = 1; reset_req = 0;
      repeat (3) cyc();

      chk("rst_done0", {31'b0, done0}, 32'h0);
      chk("rst_done1", {31'b0, done1}, 32'h0);
      chk("rst_coll0", {31'b0, coll0}, 32'h0);
      chk("rst_rdv", {28'b0, rv}, 32'h0);
      chk("rst_rda0", ia0.readdata, 32'h0);
      chk("rst_rdb1", ib1.readdata, 32'h0);
      chk("rst_wait", {31'b0, ib1.waitrequest}, 32'h1);

      reset_n = 1;
      count_wait(n);
      chk("clear_cycles", n, 16);
      chk("init_done0", {31'b0, done0}, 32'h1);
      chk("init_done1", {31'b0, done1}, 32'h1);
      chk("wait_b_low", {31'b0, ib1.waitrequest}, 32'h0);
      cyc();

      expect_rd(0, 32'h0, 0);
      issue(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);

      issue(0, 1, 3, 4'hF, 32'hAABBCCDD, 0, 0, 0, 0, 0);
      issue(0, 1, 3, 4'h5, 32'h11223344, 0, 0, 0, 0, 0);
      expect_rd(1, 32'hAA22CC44, 0);
      issue(0, 0, 0, 0, 0, 1, 0, 3, 0, 0);

      issue(0, 1, 0, 4'hF, 32'h10, 0, 0, 0, 0, 0);
      issue(0, 1, 1, 4'hF, 32'h11, 0, 0, 0, 0, 0);
      issue(0, 1, 2, 4'hF, 32'h12, 0, 0, 0, 0, 0);
      expect_rd(0, 32'h10, 0);
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_rd(0, 32'h11, 0);
      issue(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_rd(0, 32'h12, 0);
      issue(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
      expect_rd(0, 32'hAA22CC44, 0);
      issue(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
      idle();
      cyc();

      chk("coll_before", {31'b0, coll0}, 32'h0);
      issue(0, 1, 7, 4'hF, 32'h1, 0, 1, 7, 4'hF, 32'h2);
      idle();
      chk("coll_set0", {31'b0, coll0}, 32'h1);
      chk("coll_set1", {31'b0, coll1}, 32'h1);
      issue(0, 1, 8, 4'hF, 32'h8, 0, 1, 10, 4'hF, 32'hA);
      expect_rd(0, 32'h1, 0);
      issue(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
      issue(0, 1, 7, 4'h1, 32'h000000AB, 0, 1, 7, 4'hF, 32'hFFFFFFFF);
      expect_rd(1, 32'h000000AB, 0);
      issue(0, 0, 0, 0, 0, 1, 0, 7, 0, 0);
      expect_rd(1, 32'hA, 0);
      issue(0, 0, 0, 0, 0, 1, 0, 10, 0, 0);
      idle();
      chk("coll_sticky", {31'b0, coll0}, 32'h1);

      issue(0, 1, 9, 4'hF, 32'h55, 0, 0, 0, 0, 0);
      expect_rd(1, 32'h55, 0);
      issue(0, 1, 9, 4'hF, 32'h66, 1, 0, 9, 0, 0);
      expect_rd(1, 32'h66, 0);
      issue(0, 0, 0, 0, 0, 1, 0, 9, 0, 0);

      issue(1, 1, 11, 4'hF, 32'h77, 0, 0, 0, 0, 0);
      expect_rd(0, 32'h77, 0);
      issue(1, 0, 11, 0, 0, 0, 0, 0, 0, 0);
      idle();
      cyc();

      expect_rd(0, 32'h66, 3);
      issue(1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
      idle();
      reset_req = 1;
      repeat (3) cyc();
      reset_req = 0;
      repeat (6) cyc();

      chk("hold_a0", ia0.readdata, 32'h66);
      chk("hold_b0", ib0.readdata, 32'h66);
      chk("hold_a1", ia1.readdata, 32'h66);
      chk("hold_b1", ib1.readdata, 32'h66);
      for (int i = 0; i < 4; i++)
         chk($sformatf("sb%0d_empty", i), sb[i].size(), 0);

      reset_n = 0;
      cyc();
      reset_n = 1;
      repeat (8) cyc();
      chk("midclear_wait", {31'b0, ia0.waitrequest}, 32'h1);
      reset_n = 0;
      cyc();
      chk("rst_coll_clr", {31'b0, coll0}, 32'h0);
      reset_n = 1;
      count_wait(n);
      chk("reclear_cycles", n, 16);
      chk("reinit_done", {31'b0, done1}, 32'h1);
      cyc();

      expect_rd(1, 32'h0, 0);
      issue(0, 0, 0, 0, 0, 1, 0, 9, 0, 0);
      idle();
      repeat (4) cyc();
      chk("final_empty", sb[1].size() + sb[3].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
